// File: rtl/ysyx_24100013_rf_wb_arbiter_pkg.sv
// Shared widths, channel indices and small helpers for the register-file
// writeback arbiter and its scoreboard.
package ysyx_24100013_rf_wb_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;

  localparam logic CH_EXU = 1'b0;
  localparam logic CH_LSU = 1'b1;

  typedef enum logic {
    GRANT_EXU = CH_EXU,
    GRANT_LSU = CH_LSU
  } grant_ch_e;

  // The round-robin pointer always moves to the channel that just lost.
  function automatic logic other_ch(input logic ch);
    return ~ch;
  endfunction

endpackage

// File: rtl/ysyx_24100013_rf_scoreboard.sv
// Per-register busy bits tracking issued-but-not-written-back destinations.
// Register 0 never becomes busy; a set on the same edge as a clear wins.
module ysyx_24100013_rf_scoreboard
  import ysyx_24100013_rf_wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_idx,
  input  logic [ADDR_WIDTH-1:0] rd_idx1,
  output logic                  rd_busy1,
  input  logic [ADDR_WIDTH-1:0] rd_idx2,
  output logic                  rd_busy2,
  input  logic [ADDR_WIDTH-1:0] waw_idx,
  output logic                  waw_busy
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0] busy;

  assign busy[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_busy
      logic bit_reg;
      logic bit_next;
      logic hit_set;
      logic hit_clr;

      assign hit_set = set_en && (set_idx == ADDR_WIDTH'(gi));
      assign hit_clr = clr_en && (clr_idx == ADDR_WIDTH'(gi));

      always_comb begin
        bit_next = bit_reg;
        if (hit_set) begin
          bit_next = 1'b1;
        end else if (hit_clr) begin
          bit_next = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bit_reg <= 1'b0;
        end else begin
          bit_reg <= bit_next;
        end
      end

      assign busy[gi] = bit_reg;
    end
  endgenerate

  assign rd_busy1 = busy[rd_idx1];
  assign rd_busy2 = busy[rd_idx2];
  assign waw_busy = busy[waw_idx];

endmodule

// File: rtl/ysyx_24100013_rf_wb_arbiter.sv
// Round-robin arbiter between EXU and LSU writebacks into a registered
// register-file write port, plus issue-side WAW/RAW tracking.
module ysyx_24100013_rf_wb_arbiter
  import ysyx_24100013_rf_wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  hazard1,
  output logic                  hazard2,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  logic                  ptr_reg;
  logic                  ptr_next;
  logic                  rf_wen_reg;
  logic                  rf_wen_next;
  logic [ADDR_WIDTH-1:0] rf_rd_reg;
  logic [ADDR_WIDTH-1:0] rf_rd_next;
  logic [DATA_WIDTH-1:0] rf_wdata_reg;
  logic [DATA_WIDTH-1:0] rf_wdata_next;

  logic      exu_grant;
  logic      lsu_grant;
  logic      wb_fire;
  grant_ch_e win_ch;

  logic      busy1;
  logic      busy2;
  logic      waw_busy;
  logic      iss_fire;

  // Grants are forced low while in reset so nothing can be accepted then.
  always_comb begin
    exu_grant = 1'b0;
    lsu_grant = 1'b0;
    if (rst_n) begin
      if (exu_valid && lsu_valid) begin
        exu_grant = (ptr_reg == CH_EXU);
        lsu_grant = (ptr_reg == CH_LSU);
      end else begin
        exu_grant = exu_valid;
        lsu_grant = lsu_valid;
      end
    end
  end

  assign exu_ready = exu_grant;
  assign lsu_ready = lsu_grant;
  assign wb_fire   = exu_grant || lsu_grant;
  assign win_ch    = lsu_grant ? GRANT_LSU : GRANT_EXU;

  always_comb begin
    ptr_next      = ptr_reg;
    rf_wen_next   = 1'b0;
    rf_rd_next    = rf_rd_reg;
    rf_wdata_next = rf_wdata_reg;
    if (wb_fire) begin
      ptr_next = other_ch(logic'(win_ch));
      if (win_ch == GRANT_LSU) begin
        rf_rd_next    = lsu_rd;
        rf_wdata_next = lsu_data;
        rf_wen_next   = (lsu_rd != '0);
      end else begin
        rf_rd_next    = exu_rd;
        rf_wdata_next = exu_data;
        rf_wen_next   = (exu_rd != '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg      <= CH_EXU;
      rf_wen_reg   <= 1'b0;
      rf_rd_reg    <= '0;
      rf_wdata_reg <= '0;
    end else begin
      ptr_reg      <= ptr_next;
      rf_wen_reg   <= rf_wen_next;
      rf_rd_reg    <= rf_rd_next;
      rf_wdata_reg <= rf_wdata_next;
    end
  end

  assign rf_wen   = rf_wen_reg;
  assign rf_rd    = rf_rd_reg;
  assign rf_wdata = rf_wdata_reg;

  // Busy bits are cleared asynchronously, so the lookups already read 0 in reset.
  assign iss_ready = !waw_busy;
  assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);
  assign hazard1   = busy1;
  assign hazard2   = busy2;

  ysyx_24100013_rf_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (iss_fire),
    .set_idx  (iss_rd),
    .clr_en   (rf_wen_reg),
    .clr_idx  (rf_rd_reg),
    .rd_idx1  (rs1),
    .rd_busy1 (busy1),
    .rd_idx2  (rs2),
    .rd_busy2 (busy2),
    .waw_idx  (iss_rd),
    .waw_busy (waw_busy)
  );

endmodule

// File: tb/tb_ysyx_24100013_rf_wb_arbiter.sv
// Directed bench: expected register-file writes are queued by the stimulus
// and popped by a monitor on every cycle that rf_wen is high.
module tb_ysyx_24100013_rf_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        exu_valid;
  logic        exu_ready;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        iss_valid;
  logic        iss_ready;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard1;
  logic        hazard2;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  ysyx_24100013_rf_wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .exu_valid (exu_valid),
    .exu_ready (exu_ready),
    .exu_rd    (exu_rd),
    .exu_data  (exu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .iss_valid (iss_valid),
    .iss_ready (iss_ready),
    .iss_rd    (iss_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .hazard1   (hazard1),
    .hazard2   (hazard2),
    .rf_wen    (rf_wen),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
    wb_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every rf_wen cycle must match the oldest expected write.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (rf_wen === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("rf_wen_unexpected", {27'd0, rf_rd}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          $display("wb rd=%0d data=0x%08h (expect rd=%0d data=0x%08h)", rf_rd, rf_wdata, e.rd, e.data);
          chk("wb_rd", {27'd0, rf_rd}, {27'd0, e.rd});
          chk("wb_data", rf_wdata, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    exu_valid = 1'b1;
    exu_rd    = 5'd1;
    exu_data  = 32'h1;
    lsu_valid = 1'b1;
    lsu_rd    = 5'd2;
    lsu_data  = 32'h2;
    iss_valid = 1'b0;
    iss_rd    = 5'd0;
    rs1       = 5'd0;
    rs2       = 5'd0;

    // Reset state, with requesters valid to prove grants are suppressed.
    #2;
    chk("rst_exu_ready", {31'd0, exu_ready}, 32'd0);
    chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    chk("rst_iss_ready", {31'd0, iss_ready}, 32'd1);
    chk("rst_hazard1", {31'd0, hazard1}, 32'd0);
    chk("rst_hazard2", {31'd0, hazard2}, 32'd0);
    chk("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst_rf_rd", {27'd0, rf_rd}, 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    tick();
    tick();
    exu_valid = 1'b0;
    lsu_valid = 1'b0;
    rst_n     = 1'b1;
    tick();

    // Single EXU writeback.
    exu_valid = 1'b1;
    exu_rd    = 5'd5;
    exu_data  = 32'h1234;
    #1;
    chk("s1_exu_ready", {31'd0, exu_ready}, 32'd1);
    push_wb(5'd5, 32'h1234);
    tick();
    exu_valid = 1'b0;
    tick();
    tick();

    // LSU writeback to x0: accepted, no write; pointer returns to EXU.
    lsu_valid = 1'b1;
    lsu_rd    = 5'd0;
    lsu_data  = 32'hFFFF_FFFF;
    rs1       = 5'd0;
    #1;
    chk("x0_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    chk("x0_exu_ready", {31'd0, exu_ready}, 32'd0);
    chk("x0_hazard1_a", {31'd0, hazard1}, 32'd0);
    tick();
    lsu_valid = 1'b0;
    #1;
    chk("x0_hazard1_b", {31'd0, hazard1}, 32'd0);
    tick();
    chk("x0_hazard1_c", {31'd0, hazard1}, 32'd0);

    // Both valid for four cycles: EXU, LSU, EXU, LSU.
    for (int i = 0; i < 4; i++) begin
      exu_valid = 1'b1;
      exu_rd    = 5'd3;
      exu_data  = 32'hA000 + i;
      lsu_valid = 1'b1;
      lsu_rd    = 5'd4;
      lsu_data  = 32'hB000 + i;
      #1;
      chk("rr_exu_ready", {31'd0, exu_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_lsu_ready", {31'd0, lsu_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i % 2 == 0) push_wb(5'd3, 32'hA000 + i);
      else            push_wb(5'd4, 32'hB000 + i);
      tick();
    end
    exu_valid = 1'b0;
    lsu_valid = 1'b0;
    rs1       = 5'd3;
    #1;
    chk("rr_no_busy_x3", {31'd0, hazard1}, 32'd0);
    tick();

    // Issue x7, then write it back; hazard persists through the rf_wen cycle.
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    #1;
    chk("iss7_ready", {31'd0, iss_ready}, 32'd1);
    tick();
    iss_valid = 1'b0;
    rs1       = 5'd7;
    #1;
    chk("iss7_hazard1", {31'd0, hazard1}, 32'd1);
    chk("iss7_waw_block", {31'd0, iss_ready}, 32'd0);
    exu_valid = 1'b1;
    exu_rd    = 5'd7;
    exu_data  = 32'h77;
    #1;
    chk("wb7_exu_ready", {31'd0, exu_ready}, 32'd1);
    push_wb(5'd7, 32'h77);
    tick();
    exu_valid = 1'b0;
    #1;
    chk("wb7_hazard_in_wen", {31'd0, hazard1}, 32'd1);
    tick();
    chk("wb7_hazard_clear", {31'd0, hazard1}, 32'd0);
    chk("wb7_iss_ready", {31'd0, iss_ready}, 32'd1);

    // Write x9 while not busy, then issue x9 on the clearing edge: set wins.
    exu_valid = 1'b1;
    exu_rd    = 5'd9;
    exu_data  = 32'h99;
    #1;
    chk("wb9_exu_ready", {31'd0, exu_ready}, 32'd1);
    push_wb(5'd9, 32'h99);
    tick();
    exu_valid = 1'b0;
    iss_valid = 1'b1;
    iss_rd    = 5'd9;
    rs2       = 5'd9;
    #1;
    chk("iss9_ready", {31'd0, iss_ready}, 32'd1);
    chk("iss9_hazard2_pre", {31'd0, hazard2}, 32'd0);
    tick();
    iss_valid = 1'b0;
    #1;
    chk("iss9_set_wins", {31'd0, hazard2}, 32'd1);
    chk("iss9_waw_block", {31'd0, iss_ready}, 32'd0);
    exu_valid = 1'b1;
    exu_data  = 32'h9A;
    #1;
    chk("wb9b_exu_ready", {31'd0, exu_ready}, 32'd1);
    push_wb(5'd9, 32'h9A);
    tick();
    exu_valid = 1'b0;
    tick();
    chk("wb9b_hazard2_clear", {31'd0, hazard2}, 32'd0);

    // Issue x12, then reset arrives during an EXU handshake to x2.
    iss_valid = 1'b1;
    iss_rd    = 5'd12;
    #1;
    chk("iss12_ready", {31'd0, iss_ready}, 32'd1);
    tick();
    iss_valid = 1'b0;
    rs1       = 5'd12;
    #1;
    chk("iss12_hazard1", {31'd0, hazard1}, 32'd1);
    exu_valid = 1'b1;
    exu_rd    = 5'd2;
    exu_data  = 32'h2222;
    #1;
    chk("rst_hs_exu_ready", {31'd0, exu_ready}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_hs_exu_ready_low", {31'd0, exu_ready}, 32'd0);
    chk("rst_hs_hazard1", {31'd0, hazard1}, 32'd0);
    chk("rst_hs_iss_ready", {31'd0, iss_ready}, 32'd1);
    chk("rst_hs_rf_rd", {27'd0, rf_rd}, 32'd0);
    chk("rst_hs_rf_wdata", rf_wdata, 32'd0);
    tick();
    exu_valid = 1'b0;
    rst_n     = 1'b1;
    tick();
    tick();
    chk("post_rst_hazard1", {31'd0, hazard1}, 32'd0);

    // Pointer must be back at EXU after reset.
    exu_valid = 1'b1;
    exu_rd    = 5'd6;
    exu_data  = 32'h66;
    lsu_valid = 1'b1;
    lsu_rd    = 5'd8;
    lsu_data  = 32'h88;
    #1;
    chk("post_rst_ptr_exu", {31'd0, exu_ready}, 32'd1);
    chk("post_rst_ptr_lsu", {31'd0, lsu_ready}, 32'd0);
    push_wb(5'd6, 32'h66);
    tick();
    exu_valid = 1'b0;
    lsu_valid = 1'b0;
    tick();
    tick();
    chk("expected_queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
